// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StReq,
    StAck,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/prog_loader_byte_pack.sv
// Little-endian byte-to-word assembler shared by the length and data phases.
module prog_loader_byte_pack
  import prog_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

  logic [31:0]     word_q, word_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // New bytes enter at the top, so after four bytes the first one sits in [7:0].
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (take_i) begin
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  // Byte shift register and byte counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  // word_o already includes the byte being taken, so the completing edge can act on it.
  assign word_o       = word_d;
  assign word_valid_o = take_i && (cnt_q == CntW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot loader: frames a length-prefixed byte stream into words, writes them to
// instruction memory and releases the core once the whole image is committed.
module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int unsigned     AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int unsigned     MAX_WORDS = 4096,
  parameter int unsigned     TIMEOUT   = 1_000_000,
  parameter int unsigned     CW        = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_i,
  output logic          byte_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic          mem_gnt_i,
  input  logic          mem_ack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          core_rst_no,
  output logic [CW-1:0] words_written_o
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e        state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   idx_q, idx_d;
  logic [CW-1:0] words_q, words_d;
  logic [TW-1:0] stall_q, stall_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          take, pack_clear, word_valid, timeout_hit, ack_fire;
  logic [31:0]   word;

  assign take        = byte_valid_i && byte_ready_o;
  assign timeout_hit = (TIMEOUT != 0) && (stall_q == TW'(TIMEOUT - 1));
  // A grant with a same-cycle ack completes the write straight from REQ.
  assign ack_fire    = ((state_q == StReq) && mem_gnt_i && mem_ack_i) ||
                       ((state_q == StAck) && mem_ack_i);

  prog_loader_byte_pack u_byte_pack (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (pack_clear),
    .take_i       (take),
    .byte_i       (byte_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    words_d    = words_q;
    stall_d    = stall_q;
    done_d     = done_q;
    err_d      = err_q;
    pack_clear = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d    = StLen;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = '0;
          stall_d    = '0;
          pack_clear = 1'b1;
        end
      end
      StLen, StData: begin
        if (take) begin
          stall_d = '0;
          if (word_valid) begin
            if (state_q == StData) begin
              state_d = StReq;
            end else if ((word == '0) || (word > 32'(MAX_WORDS))) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else begin
              len_d   = word;
              idx_d   = '0;
              state_d = StData;
            end
          end
        end else if (timeout_hit) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          stall_d = stall_q + TW'(1);
        end
      end
      StReq: begin
        if (mem_gnt_i && !mem_ack_i) state_d = StAck;
      end
      StAck: ;
      default: state_d = StIdle;
    endcase
    if (ack_fire) begin
      idx_d = idx_q + 32'd1;
      if (words_q != '1) words_d = words_q + CW'(1);
      if (idx_q + 32'd1 == len_q) begin
        state_d = StDone;
        done_d  = 1'b1;
      end else begin
        state_d = StData;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state; request fields are zero unless requesting.
  always_comb begin
    byte_ready_o    = (state_q == StLen) || (state_q == StData);
    busy_o          = byte_ready_o || (state_q == StReq) || (state_q == StAck);
    mem_req_o       = (state_q == StReq);
    mem_we_o        = mem_req_o;
    mem_be_o        = mem_req_o ? 4'hF : 4'h0;
    mem_addr_o      = mem_req_o ? (BASE_ADDR + AW'(idx_q << 2)) : '0;
    mem_wdata_o     = mem_req_o ? word : '0;
    core_rst_no     = (state_q == StDone);
    done_o          = done_q;
    err_o           = err_q;
    words_written_o = words_q;
  end

endmodule
